// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for an external single-clock RAM with registered read data.
// Holds read/write pointers, status flags and sticky error flags; data lives in the RAM.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int AFULL_LEVEL = 2**ADDR_WIDTH - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE   = 1;
    localparam logic [ADDR_WIDTH:0] AFULL_CNT = AFULL_LEVEL[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic                push_acc;
    logic                pop_acc;

    always_comb begin
        empty       = (wr_ptr == rd_ptr);
        full        = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                      (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
        count       = wr_ptr - rd_ptr;
        almost_full = (count >= AFULL_CNT);
        pop_acc     = pop & ~empty & ~flush;
        // A pop in the same cycle frees the slot the push lands in (RAM reads before write).
        push_acc    = push & ~flush & (~full | pop_acc);
    end

    always_comb begin
        ram_we         = push_acc;
        ram_data       = push_data;
        ram_write_addr = wr_ptr[ADDR_WIDTH-1:0];
        ram_read_addr  = rd_ptr[ADDR_WIDTH-1:0];
        pop_data       = ram_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_acc)
                rd_ptr <= rd_ptr + PTR_ONE;
            pop_valid <= pop_acc;
            if (push && !push_acc)
                overflow <= 1'b1;
            if (pop && empty)
                underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural read-before-write RAM.
// Vector table covers basic ordering, underflow and flush; hand sequences cover full, wrap and reset.
module tb_ram_fifo_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          pop = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic [DW-1:0] ram_data;
    logic          ram_we;
    logic [AW-1:0] ram_write_addr;
    logic [AW-1:0] ram_read_addr;
    logic [DW-1:0] ram_q = '0;

    logic [DW-1:0] mem [16];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LEVEL(14)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .pop(pop),
        .flush(flush), .pop_data(pop_data), .pop_valid(pop_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .count(count), .overflow(overflow),
        .underflow(underflow), .ram_data(ram_data), .ram_we(ram_we),
        .ram_write_addr(ram_write_addr), .ram_read_addr(ram_read_addr), .ram_q(ram_q)
    );

    // Registered read of the old contents, then the write.
    always @(posedge clk) begin
        ram_q <= mem[ram_read_addr];
        if (ram_we)
            mem[ram_write_addr] <= ram_data;
    end

    typedef struct {
        bit          push;
        bit          pop;
        bit          flush;
        logic [31:0] data;
        bit          we;
        bit          pv;
        bit          chk_pd;
        logic [31:0] pd;
        int          cnt;
        bit          emp;
        bit          ovf;
        bit          unf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit p, input bit q, input bit f, input logic [31:0] d);
        push      = p;
        pop       = q;
        flush     = f;
        push_data = d;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_afull"}, almost_full, 0);
        chk({tag, "_pv"}, pop_valid, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_unf"}, underflow, 0);
    endtask

    task automatic fill16;
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 32'h100 + i);
            chk("fill_we", ram_we, 1);
            tick;
            chk("fill_count", count, i + 1);
            chk("fill_afull", almost_full, (i + 1) >= 14);
            chk("fill_full", full, (i + 1) == 16);
        end
    endtask

    initial begin
        vec_t        vt [16];
        logic [31:0] mq [$];
        bit          p, q, pa, pu, unf_m;
        logic [31:0] exp_pd;

        // push, pop, flush, data, we, pv, chk_pd, pd, cnt, emp, ovf, unf
        vt[0]  = '{1, 0, 0, 32'h11, 1, 0, 0, 32'h0,  1, 0, 0, 0};
        vt[1]  = '{1, 0, 0, 32'h22, 1, 0, 0, 32'h0,  2, 0, 0, 0};
        vt[2]  = '{1, 0, 0, 32'h33, 1, 0, 0, 32'h0,  3, 0, 0, 0};
        vt[3]  = '{0, 1, 0, 32'h0,  0, 1, 1, 32'h11, 2, 0, 0, 0};
        vt[4]  = '{0, 1, 0, 32'h0,  0, 1, 1, 32'h22, 1, 0, 0, 0};
        vt[5]  = '{0, 1, 0, 32'h0,  0, 1, 1, 32'h33, 0, 1, 0, 0};
        vt[6]  = '{0, 0, 0, 32'h0,  0, 0, 0, 32'h0,  0, 1, 0, 0};
        vt[7]  = '{0, 1, 0, 32'h0,  0, 0, 0, 32'h0,  0, 1, 0, 1};
        vt[8]  = '{1, 1, 0, 32'h44, 1, 0, 0, 32'h0,  1, 0, 0, 1};
        vt[9]  = '{0, 1, 0, 32'h0,  0, 1, 1, 32'h44, 0, 1, 0, 1};
        vt[10] = '{1, 0, 0, 32'h50, 1, 0, 0, 32'h0,  1, 0, 0, 1};
        vt[11] = '{1, 0, 0, 32'h51, 1, 0, 0, 32'h0,  2, 0, 0, 1};
        vt[12] = '{1, 0, 0, 32'h52, 1, 0, 0, 32'h0,  3, 0, 0, 1};
        vt[13] = '{1, 0, 0, 32'h53, 1, 0, 0, 32'h0,  4, 0, 0, 1};
        vt[14] = '{1, 0, 0, 32'h54, 1, 0, 0, 32'h0,  5, 0, 0, 1};
        vt[15] = '{1, 0, 1, 32'h55, 0, 0, 0, 32'h0,  0, 1, 0, 0};

        #2;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        foreach (vt[i]) begin
            drive(vt[i].push, vt[i].pop, vt[i].flush, vt[i].data);
            chk($sformatf("vec%0d_we", i), ram_we, vt[i].we);
            tick;
            chk($sformatf("vec%0d_pv", i), pop_valid, vt[i].pv);
            if (vt[i].chk_pd)
                chk($sformatf("vec%0d_pd", i), pop_data, vt[i].pd);
            chk($sformatf("vec%0d_count", i), count, vt[i].cnt);
            chk($sformatf("vec%0d_empty", i), empty, vt[i].emp);
            chk($sformatf("vec%0d_ovf", i), overflow, vt[i].ovf);
            chk($sformatf("vec%0d_unf", i), underflow, vt[i].unf);
        end

        // Fill to full, overflow attempt, drain intact.
        fill16;
        drive(1, 0, 0, 32'hDEAD);
        chk("ovf_we", ram_we, 0);
        tick;
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 16);
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 0);
            tick;
            chk("drain1_pv", pop_valid, 1);
            chk("drain1_pd", pop_data, 32'h100 + i);
        end
        drive(0, 0, 0, 0);
        tick;
        chk("drain1_empty", empty, 1);
        chk("ovf_sticky", overflow, 1);
        drive(0, 0, 1, 0);
        tick;
        chk("flush_ovf", overflow, 0);

        // Full with simultaneous push and pop.
        fill16;
        drive(1, 1, 0, 32'hAA);
        chk("fullpp_we", ram_we, 1);
        tick;
        chk("fullpp_pv", pop_valid, 1);
        chk("fullpp_pd", pop_data, 32'h100);
        chk("fullpp_count", count, 16);
        chk("fullpp_ovf", overflow, 0);
        for (int i = 1; i <= 16; i++) begin
            drive(0, 1, 0, 0);
            tick;
            chk("drain2_pd", pop_data, (i == 16) ? 32'hAA : 32'h100 + i);
        end
        drive(0, 0, 0, 0);
        tick;
        chk("drain2_empty", empty, 1);

        // Mixed traffic across pointer wrap against a queue model.
        unf_m = 0;
        for (int i = 0; i < 40; i++) begin
            p  = (i % 4) != 3;
            q  = (i % 3) != 0;
            pa = q && (mq.size() > 0);
            pu = p && ((mq.size() < 16) || pa);
            if (q && mq.size() == 0)
                unf_m = 1;
            exp_pd = pa ? mq[0] : 32'h0;
            if (pa)
                void'(mq.pop_front());
            if (pu)
                mq.push_back(32'h200 + i);
            drive(p, q, 0, 32'h200 + i);
            tick;
            chk("wrap_pv", pop_valid, pa);
            if (pa)
                chk("wrap_pd", pop_data, exp_pd);
            chk("wrap_count", count, mq.size());
            chk("wrap_unf", underflow, unf_m);
        end

        // Asynchronous reset with a pop in flight.
        drive(1, 0, 0, 32'h300);
        tick;
        drive(0, 1, 0, 0);
        tick;
        chk("pre_reset_pv", pop_valid, 1);
        drive(0, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_state("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 32'h31 + i);
            tick;
        end
        chk("post_reset_count", count, 3);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0);
            tick;
            chk("post_reset_pv", pop_valid, 1);
            chk("post_reset_pd", pop_data, 32'h31 + i);
        end
        drive(0, 0, 0, 0);
        tick;
        chk("post_reset_empty", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width; must match the attached RAM.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, RAM address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter AFULL_LEVEL, default 2**ADDR_WIDTH-2, count at or above which almost_full asserts.
REQ-004 clk  input  1  single clock, all state updates on posedge; one clock; reset is asynchronous and active-low.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 push  input  1  write request; push_data  input  DATA_WIDTH  write word.
REQ-007 pop  input  1  read request.
REQ-008 flush  input  1  synchronous clear of FIFO contents and error flags.
REQ-009 pop_data  output  DATA_WIDTH  read word, valid when pop_valid=1.
REQ-010 pop_valid  output  1  registered; marks pop_data valid.
REQ-011 full, empty, almost_full  output  1 each  status flags.
REQ-012 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-013 overflow, underflow  output  1 each  sticky error flags.
REQ-014 ram_data  output  DATA_WIDTH  RAM write data; ram_we  output  1  RAM write enable.
REQ-015 ram_write_addr, ram_read_addr  output  ADDR_WIDTH  RAM addresses.
REQ-016 ram_q  input  DATA_WIDTH  RAM registered read data (1-cycle latency, read-before-write on same address).

Function
REQ-017 SHALL keep wr_ptr and rd_ptr of ADDR_WIDTH+1 bits; RAM addresses are the low ADDR_WIDTH bits; pointers wrap modulo 2*DEPTH.
REQ-018 SHALL derive empty = (wr_ptr == rd_ptr); full = low bits equal and MSBs differ; count = wr_ptr - rd_ptr (mod 2*DEPTH).
REQ-019 SHALL assert almost_full combinationally when count >= AFULL_LEVEL.
REQ-020 pop_acc = pop & ~empty & ~flush; push_acc = push & ~flush & (~full | pop_acc).
REQ-021 SHALL drive ram_we = push_acc, ram_data = push_data, ram_write_addr = wr_ptr low bits, all combinationally.
REQ-022 SHALL drive ram_read_addr = rd_ptr low bits combinationally every cycle.
REQ-023 On push_acc: wr_ptr += 1 at the clock edge; on pop_acc: rd_ptr += 1; both may occur in one cycle, count unchanged.
REQ-024 pop_valid SHALL equal pop_acc registered one cycle; pop_data SHALL pass ram_q through; latency pop->data = 1 cycle.
REQ-025 Full with simultaneous push and pop: both accepted; pop returns the oldest word (RAM read-before-write), new word stored in the same slot.
REQ-026 Empty with simultaneous push and pop: push accepted, pop rejected, underflow set; no bypass of push_data to pop_data.
REQ-027 push while full without pop_acc SHALL be dropped (no RAM write, pointers held) and set overflow.
REQ-028 pop while empty SHALL be ignored and set underflow; pop_valid stays 0 next cycle.
REQ-029 overflow/underflow SHALL remain set until flush or reset.
REQ-030 flush SHALL, at the next edge, zero wr_ptr, rd_ptr, overflow, underflow and pop_valid; push/pop in the flush cycle are ignored and flag no errors; ram_we=0 during flush.
REQ-031 RAM contents are not cleared by flush or reset; stale data is unreachable because pointers are equal.

Reset
REQ-032 While rst_n=0, asynchronously: wr_ptr=0, rd_ptr=0, pop_valid=0, overflow=0, underflow=0; hence empty=1, full=0, almost_full=0, count=0.
REQ-033 Reset asserted mid-operation SHALL discard all contents; in-flight pop_valid clears immediately.
REQ-034 First accepted push or pop SHALL be the first rising edge with rst_n=1.

Verification
REQ-035 Push 0x11,0x22,0x33 on consecutive cycles, then pop three times -> pop_valid on 3 cycles one cycle after each pop, data 0x11,0x22,0x33; empty=1, count=0 after.
REQ-036 Push 16 words (default params) -> full=1, count=16, almost_full asserted from count=14; 17th push -> no ram_we, overflow=1, contents intact on drain.
REQ-037 Full FIFO, push 0xAA with pop same cycle -> pop returns oldest word, count stays 16, 0xAA emerges last after draining; no overflow.
REQ-038 Empty FIFO, pop -> underflow=1, pop_valid=0; push+pop same cycle on empty -> count=1, underflow set, no pop_valid.
REQ-039 Fill 5 words, assert flush with push=1 -> next cycle count=0, empty=1, overflow=underflow=0, no ram_we in flush cycle.
REQ-040 Run 40 push/pop cycles across pointer wrap, then assert rst_n=0 mid-stream -> all outputs at reset values immediately, subsequent push/pop sequence data ordering correct.
